// File: rtl/aes_seq_pkg.sv
// Shared types and sizes for the AES128 input sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {FILL, WAIT, READ, CAPT} seq_state_t;

  localparam int unsigned BLK_W     = 128;
  localparam int unsigned NUM_WORDS = 4;

endpackage

// File: rtl/aes_input_sequencer.sv
// Feeds host words into the 32-to-128 fifo_in, drains each full block into a
// holding register and hands it to the AES core over valid/ready.
module aes_input_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = aes_seq_pkg::NUM_WORDS,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 host_valid,
  input  logic [WORD_W-1:0]    host_data,
  output logic                 host_ready,
  output logic                 fifo_write_en,
  output logic [WORD_W-1:0]    fifo_data_in,
  output logic                 fifo_read_en,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [BLK_W-1:0]     fifo_data_out,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [BLK_W-1:0]     blk_data,
  output logic [BLK_CNT_W-1:0] blk_count,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 run_q;
  logic                 blk_valid_q;
  logic [BLK_W-1:0]     blk_data_q;
  logic [BLK_CNT_W-1:0] blk_count_q;
  logic                 err_q;

  logic                 handshake;
  logic                 out_free;
  logic                 capt;
  logic                 err_set;

  assign handshake = blk_valid_q & blk_ready;
  assign out_free  = ~blk_valid_q | blk_ready;

  // run_q keeps host_ready low while reset is asserted and for the release cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    host_ready    = 1'b0;
    fifo_write_en = 1'b0;
    fifo_read_en  = 1'b0;
    capt          = 1'b0;
    err_set       = 1'b0;
    case (state_q)
      FILL: begin
        host_ready = run_q;
        if (host_valid && run_q) begin
          fifo_write_en = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            state_d = out_free ? READ : WAIT;
          end
        end
      end
      WAIT: begin
        if (out_free) state_d = READ;
      end
      READ: begin
        fifo_read_en = 1'b1;
        err_set      = ~fifo_full;
        state_d      = CAPT;
      end
      CAPT: begin
        capt    = 1'b1;
        err_set = ~fifo_empty;
        cnt_d   = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign fifo_data_in = fifo_write_en ? host_data : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      // a capture in the same cycle as a handshake keeps the register full
      if (capt) begin
        blk_valid_q <= 1'b1;
        blk_data_q  <= fifo_data_out;
      end else if (handshake) begin
        blk_valid_q <= 1'b0;
      end
      if (handshake) blk_count_q <= blk_count_q + BLK_CNT_W'(1);
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign blk_count = blk_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_input_sequencer.sv
// Bench for aes_input_sequencer: fifo_in behaviour model, scripted AES ready,
// vector table, directed corner sequences and a randomized scoreboard run.
module tb_aes_input_sequencer;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned BLK_CNT_W = 16;
  localparam int unsigned BLK_W     = 128;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 host_valid;
  logic [WORD_W-1:0]    host_data;
  logic                 host_ready;
  logic                 fifo_write_en;
  logic [WORD_W-1:0]    fifo_data_in;
  logic                 fifo_read_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BLK_W-1:0]     fifo_data_out;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [BLK_W-1:0]     blk_data;
  logic [BLK_CNT_W-1:0] blk_count;
  logic                 err;
  logic                 err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_input_sequencer #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .BLK_CNT_W(BLK_CNT_W)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .fifo_read_en(fifo_read_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_count(blk_count), .err(err), .err_clr(err_clr)
  );

  // fifo_in: four word slots, whole block read out one cycle after read_en
  logic [WORD_W-1:0] fmem [NUM_WORDS];
  logic [2:0]        fcnt;
  logic [BLK_W-1:0]  fout;
  logic              force_nf;

  assign fifo_full     = (fcnt == 3'd4) && !force_nf;
  assign fifo_empty    = (fcnt == 3'd0);
  assign fifo_data_out = fout;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fcnt <= 3'd0;
      fout <= '0;
    end else if (fifo_read_en) begin
      fout <= {fmem[0], fmem[1], fmem[2], fmem[3]};
      fcnt <= 3'd0;
    end else if (fifo_write_en && fcnt < 3'd4) begin
      fmem[fcnt[1:0]] <= fifo_data_in;
      fcnt            <= fcnt + 3'd1;
    end
  end

  task automatic check(input string name, input logic [BLK_W-1:0] act,
                       input logic [BLK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted words grouped four at a time form the expected block stream
  logic [WORD_W-1:0]    wq [$];
  logic [BLK_W-1:0]     bq [$];
  logic [BLK_CNT_W-1:0] exp_cnt;
  logic                 prev_hold;
  logic [BLK_W-1:0]     prev_data;
  int                   wr_pulses = 0;
  int                   rd_pulses = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      wq.delete();
      bq.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 128'(blk_valid), 128'(1));
        check("hold_data", blk_data, prev_data);
      end
      check("wr_en_vs_accept", 128'(fifo_write_en), 128'(host_valid & host_ready));
      check("no_write_when_full", 128'(fifo_write_en && fcnt == 3'd4), 128'(0));
      if (host_valid && host_ready) begin
        check("fifo_data_in", 128'(fifo_data_in), 128'(host_data));
        wq.push_back(host_data);
        wr_pulses++;
        if (wq.size() == NUM_WORDS) begin
          bq.push_back({wq[0], wq[1], wq[2], wq[3]});
          wq.delete();
        end
      end
      if (fifo_read_en) rd_pulses++;
      if (blk_valid && blk_ready) begin
        if (bq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_block: got %0h, expected no block", blk_data);
        end else begin
          check("sb_blk_data", blk_data, bq.pop_front());
        end
        check("sb_blk_count", 128'(blk_count), 128'(exp_cnt));
        exp_cnt = exp_cnt + 16'd1;
      end
      prev_hold = blk_valid && !blk_ready;
      prev_data = blk_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Offers one word and returns 2ns after the edge that accepted it
  task automatic send_word(input logic [WORD_W-1:0] d);
    int t = 0;
    host_valid = 1'b1;
    host_data  = d;
    @(negedge clk);
    while (!host_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got host_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #2;
    host_valid = 1'b0;
    host_data  = $urandom;
  endtask

  task automatic send_block(input logic [0:3][WORD_W-1:0] w);
    for (int k = 0; k < 4; k++) send_word(w[k]);
  endtask

  typedef struct packed {
    logic [0:3][WORD_W-1:0] w;
    logic [BLK_W-1:0]       blk;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int                     cnt_ref;
    int                     w0, r0;
    logic [0:3][WORD_W-1:0] bw;

    vecs[0].w   = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    vecs[0].blk = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    vecs[1].w   = {32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[1].blk = 128'h00000000_FFFFFFFF_00000000_FFFFFFFF;
    vecs[2].w   = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[2].blk = 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D;
    vecs[3].w   = {32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFE};
    vecs[3].blk = 128'h80000000_00000001_7FFFFFFF_FFFFFFFE;

    n_rst      = 1'b0;
    host_valid = 1'b1;
    host_data  = 32'hFFFFFFFF;
    blk_ready  = 1'b0;
    err_clr    = 1'b0;
    force_nf   = 1'b0;
    tick(3);
    check("rst_blk_valid", 128'(blk_valid), 128'(0));
    check("rst_host_ready", 128'(host_ready), 128'(0));
    check("rst_write_en", 128'(fifo_write_en), 128'(0));
    check("rst_data_in", 128'(fifo_data_in), 128'(0));
    check("rst_read_en", 128'(fifo_read_en), 128'(0));
    check("rst_blk_data", blk_data, 128'(0));
    check("rst_blk_count", 128'(blk_count), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    host_valid = 1'b0;
    n_rst      = 1'b1;
    tick(1);
    check("post_rst_host_ready", 128'(host_ready), 128'(1));

    // T1: reset in the middle of a fill
    send_word(32'h0BAD0001);
    send_word(32'h0BAD0002);
    n_rst = 1'b0;
    #1;
    check("t1_rst_valid", 128'(blk_valid), 128'(0));
    check("t1_rst_ready", 128'(host_ready), 128'(0));
    tick(2);
    n_rst = 1'b1;
    tick(1);
    check("t1_host_ready", 128'(host_ready), 128'(1));
    check("t1_blk_valid", 128'(blk_valid), 128'(0));
    check("t1_err", 128'(err), 128'(0));
    check("t1_blk_count", 128'(blk_count), 128'(0));
    check("t1_fifo_empty", 128'(fifo_empty), 128'(1));
    cnt_ref = 0;

    // T2 + vector table: back-to-back words, core always ready
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_block(vecs[i].w);
      check("tbl_read_en", 128'(fifo_read_en), 128'(1));
      check("tbl_valid_early", 128'(blk_valid), 128'(0));
      tick(1);
      check("tbl_fifo_empty", 128'(fifo_empty), 128'(1));
      tick(1);
      check("tbl_blk_valid", 128'(blk_valid), 128'(1));
      check("tbl_blk_data", blk_data, vecs[i].blk);
      tick(1);
      cnt_ref++;
      check("tbl_blk_count", 128'(blk_count), 128'(cnt_ref));
      check("tbl_valid_drop", 128'(blk_valid), 128'(0));
    end

    // T3: output back-pressure stalls the second fill in WAIT
    blk_ready = 1'b0;
    bw = {32'h12345678, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    send_block(bw);
    tick(2);
    check("t3_first_valid", 128'(blk_valid), 128'(1));
    check("t3_first_data", blk_data, 128'h12345678_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    bw = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_block(bw);
    host_valid = 1'b1;
    host_data  = 32'h5555AAAA;
    tick(3);
    check("t3_stall_ready", 128'(host_ready), 128'(0));
    check("t3_held_data", blk_data, 128'h12345678_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    check("t3_fifo_full", 128'(fifo_full), 128'(1));
    host_valid = 1'b0;
    blk_ready  = 1'b1;
    tick(1);
    check("t3_first_taken", 128'(blk_valid), 128'(0));
    tick(2);
    check("t3_second_data", blk_data, 128'h11111111_22222222_33333333_44444444);
    tick(1);
    cnt_ref += 2;
    check("t3_blk_count", 128'(blk_count), 128'(cnt_ref));

    // T4: host_valid toggling every cycle
    w0 = wr_pulses;
    r0 = rd_pulses;
    for (int k = 0; k < 4; k++) begin
      send_word(32'hA5A50000 + 32'(k));
      tick(1);
    end
    tick(4);
    cnt_ref++;
    check("t4_write_pulses", 128'(wr_pulses - w0), 128'(4));
    check("t4_read_pulses", 128'(rd_pulses - r0), 128'(1));
    check("t4_blk_count", 128'(blk_count), 128'(cnt_ref));

    // T5: core ready held through the capture of the next block
    blk_ready = 1'b0;
    send_block(vecs[2].w);
    tick(2);
    send_block(vecs[3].w);
    tick(1);
    blk_ready = 1'b1;
    tick(3);
    blk_ready = 1'b0;
    check("t5_valid", 128'(blk_valid), 128'(1));
    check("t5_new_data", blk_data, vecs[3].blk);
    check("t5_count_once", 128'(blk_count), 128'(cnt_ref + 1));
    blk_ready = 1'b1;
    tick(1);
    cnt_ref += 2;
    check("t5_blk_count", 128'(blk_count), 128'(cnt_ref));

    // T6: sticky err, set wins over a simultaneous clear
    force_nf = 1'b1;
    send_block(vecs[0].w);
    tick(1);
    force_nf = 1'b0;
    check("t6_err_set", 128'(err), 128'(1));
    tick(2);
    cnt_ref++;
    send_block(vecs[1].w);
    tick(3);
    cnt_ref++;
    check("t6_err_sticky", 128'(err), 128'(1));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t6_err_clr", 128'(err), 128'(0));
    force_nf = 1'b1;
    err_clr  = 1'b1;
    send_block(vecs[2].w);
    tick(1);
    check("t6_set_over_clr", 128'(err), 128'(1));
    force_nf = 1'b0;
    err_clr  = 1'b0;
    tick(2);
    cnt_ref++;
    check("t6_err_still", 128'(err), 128'(1));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t6_err_final", 128'(err), 128'(0));
    check("t6_blk_count", 128'(blk_count), 128'(cnt_ref));

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      host_valid = ($urandom_range(0, 9) < 7);
      host_data  = $urandom;
      blk_ready  = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    host_valid = 1'b0;
    blk_ready  = 1'b1;
    tick(20);
    check("rnd_drained", 128'(bq.size()), 128'(0));
    check("rnd_err", 128'(err), 128'(0));
    check("rnd_count_model", 128'(blk_count), 128'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
